rob_commit_unit: RTL and testbench
==================================

// Module: rob_commit_unit
// PURPOSE
//  In-order reorder buffer on the far side of the rename stage. Accepts renamed instrs
//  (new pdst and prev pdst), tracks out-of-order completion, and retires one instr/cycle.
//  Retirement returns prev pdst to rename for freelist release (p_commit/prev_prf_idx).
//  Also holds the single outstanding branch checkpoint and flushes younger entries on a mispredict.
// PARAMETERS
//  DEPTH   16               entries; power of 2, >=4
//  TAG_W   $clog2(DEPTH)    ROB tag width (derived; do not override)
// PORTS
//  clk_i                 in   1      clock
//  rst_ni                in   1      async reset, active-low
//  alloc_valid_i         in   1      renamed instr offered (rinstr.valid && !StallD)
//  alloc_ready_o         out  1      ROB can accept this cycle
//  alloc_pdst_i          in   6      new physical rd
//  alloc_pdst_valid_i    in   1      instr writes rd (pdst!=0)
//  alloc_prev_i          in   6      prev physical rd mapping
//  alloc_prev_valid_i    in   1      prev mapping is freeable
//  alloc_is_branch_i     in   1      branch/jump; opens the checkpoint
//  alloc_tag_o           out  TAG_W  tag given to the accepted instr (= tail)
//  wb_valid_i[3]         in   3      completion strobes, 3 writeback ports
//  wb_tag_i[3]           in   3xTAG_W  completing ROB tags
//  br_result_valid_i     in   1      pending branch resolved
//  br_result_hit_i       in   1      1=predicted correctly, 0=mispredict
//  commit_valid_o        out  1      head retires this cycle (drives p_commit.valid/ready)
//  commit_pdst_o         out  6      retiring pdst
//  commit_prev_o         out  6      prev pdst to free (prev_prf_idx_i of rename)
//  commit_prev_valid_o   out  1      free commit_prev_o
//  commit_spec_o         out  1      retiring entry younger than pending branch
//  branch_pending_o      out  1      checkpoint open
//  rob_empty_o           out  1      count==0
//  rob_full_o            out  1      count==DEPTH
// BEHAVIOUR
//  - State: entry arrays {valid,done,pdst,pdst_v,prev,prev_v,is_br}; head,tail TAG_W; count TAG_W+1;
//    br_pending, br_tag. Pointers wrap modulo DEPTH.
//  - Reset: all entries invalid, head=tail=count=0, br_pending=0. Outputs: alloc_ready_o=1, alloc_tag_o=0,
//    commit_* = 0, branch_pending_o=0, rob_empty_o=1, rob_full_o=0. Reset mid-op discards all entries.
//  - alloc_ready_o = !rob_full_o && !(br_result_valid_i && !br_result_hit_i) (combinational).
//  - Alloc fires on alloc_valid_i && alloc_ready_o: write entry[tail], done=0, tail++, count++;
//    alloc_tag_o is combinational = tail. If is_branch: br_pending<=1, br_tag<=tail.
//    Branch alloc while br_pending is a protocol violation (rename stalls via branch_active); assert.
//  - Writeback: each wb_valid_i[k] sets done[wb_tag_i[k]] next edge; wb to an invalid entry is ignored.
//    Duplicate tags on multiple ports in same cycle are legal (idempotent).
//  - Commit (comb, 0-cycle): commit_valid_o = entry[head].valid && done[head] &&
//    !(br_pending && head==br_tag). Branch entry retires only after resolution (br_pending cleared).
//    On fire: entry[head].valid<=0, head++, count--. commit_* outputs carry head fields; 0 when !commit_valid_o.
//  - commit_spec_o = commit_valid_o && br_pending && entry is younger than br_tag; structurally 0 in
//    this config (commit blocks at branch) but driven by that rule, not tied off.
//  - Resolve: br_result_valid_i with br_pending=0 ignored. hit=1 -> br_pending<=0 next edge.
//    hit=0 -> invalidate entries (br_tag, tail) exclusive of br_tag; tail<=br_tag+1 (mod DEPTH);
//    count<=distance(head,br_tag)+1 minus same-cycle commit; br_pending<=0; same-cycle alloc is blocked.
//    Same-cycle wb to flushed tags dropped.
//  - Simultaneous alloc+commit: count unchanged; legal when full only if commit fires (ready still 0 when full:
//    no full-bypass). Empty + alloc: no same-cycle commit (done=0).
//  - Age compare uses (tag-head) mod DEPTH.
// CONFIGURATION
//  ROB_PERF_CNT_EN defined: adds outputs perf_commits_o[31:0], perf_flushes_o[31:0], perf_full_cycles_o[31:0];
//    increment per commit / mispredict flush / cycle rob_full_o=1; reset 0; wrap at 2^32.
//  Undefined: those ports and counters absent; all other behaviour identical.
// TESTING
//  - Fill: 16 allocs no wb -> tags 0..15, rob_full_o=1, alloc_ready_o=0, commit_valid_o=0.
//  - OoO wb: alloc tags 0,1,2; wb 2 then 1 then 0 -> commits 0,1,2 on consecutive cycles, in order,
//    commit_prev_o matching alloc_prev_i of each.
//  - Wrap: 40 alloc/wb/commit streams at steady state -> tail wraps 15->0, no lost or duplicated commit.
//  - Mispredict: alloc br at tag 3, then tags 4..7; wb all; br hit=0 -> tail=4, count=4, tags 4..7 never commit,
//    next alloc gets tag 4; commit stalls at tag 3 until resolve.
//  - Hit: same as above with hit=1 -> branch_pending_o 0 next cycle, tags 3..7 commit in order.
//  - Full+commit same cycle, then async reset mid-stream -> all outputs at reset values, rob_empty_o=1.

Source files
------------

// File: rtl/rob_commit_unit_if.sv
// Rename <-> ROB port bundle: allocation, writeback, branch resolve and commit.
// Perf counter outputs exist only when ROB_PERF_CNT_EN is defined.
interface rob_commit_unit_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned TAG_W  = $clog2(DEPTH);
    localparam int unsigned REG_W  = 6;
    localparam int unsigned NUM_WB = 3;

    logic                              alloc_valid_i;
    logic                              alloc_ready_o;
    logic [REG_W-1:0]                  alloc_pdst_i;
    logic                              alloc_pdst_valid_i;
    logic [REG_W-1:0]                  alloc_prev_i;
    logic                              alloc_prev_valid_i;
    logic                              alloc_is_branch_i;
    logic [TAG_W-1:0]                  alloc_tag_o;

    logic [NUM_WB-1:0]                 wb_valid_i;
    logic [NUM_WB-1:0][TAG_W-1:0]      wb_tag_i;

    logic                              br_result_valid_i;
    logic                              br_result_hit_i;

    logic                              commit_valid_o;
    logic [REG_W-1:0]                  commit_pdst_o;
    logic [REG_W-1:0]                  commit_prev_o;
    logic                              commit_prev_valid_o;
    logic                              commit_spec_o;
    logic                              branch_pending_o;
    logic                              rob_empty_o;
    logic                              rob_full_o;
`ifdef ROB_PERF_CNT_EN
    logic [31:0]                       perf_commits_o;
    logic [31:0]                       perf_flushes_o;
    logic [31:0]                       perf_full_cycles_o;
`endif

    // Rename / execute side
    modport master (
        output alloc_valid_i, alloc_pdst_i, alloc_pdst_valid_i, alloc_prev_i,
               alloc_prev_valid_i, alloc_is_branch_i, wb_valid_i, wb_tag_i,
               br_result_valid_i, br_result_hit_i,
`ifdef ROB_PERF_CNT_EN
        input  perf_commits_o, perf_flushes_o, perf_full_cycles_o,
`endif
        input  alloc_ready_o, alloc_tag_o, commit_valid_o, commit_pdst_o,
               commit_prev_o, commit_prev_valid_o, commit_spec_o,
               branch_pending_o, rob_empty_o, rob_full_o
    );

    // ROB side
    modport slave (
        input  alloc_valid_i, alloc_pdst_i, alloc_pdst_valid_i, alloc_prev_i,
               alloc_prev_valid_i, alloc_is_branch_i, wb_valid_i, wb_tag_i,
               br_result_valid_i, br_result_hit_i,
`ifdef ROB_PERF_CNT_EN
        output perf_commits_o, perf_flushes_o, perf_full_cycles_o,
`endif
        output alloc_ready_o, alloc_tag_o, commit_valid_o, commit_pdst_o,
               commit_prev_o, commit_prev_valid_o, commit_spec_o,
               branch_pending_o, rob_empty_o, rob_full_o
    );
endinterface

// File: rtl/rob_commit_unit.sv
// In-order reorder buffer: allocates renamed instrs, tracks OoO completion, retires one per
// cycle and flushes younger entries on a mispredict. ROB_PERF_CNT_EN adds perf counters.
module rob_commit_unit #(
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    rob_commit_unit_if.slave rob_if
);
    localparam int unsigned TAG_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = TAG_W + 1;
    localparam int unsigned REG_W  = 6;
    localparam int unsigned NUM_WB = 3;
    localparam int unsigned WB_IW  = 2;

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic             valid;
        logic             done;
        logic [REG_W-1:0] pdst;
        logic             pdst_v;
        logic [REG_W-1:0] prev;
        logic             prev_v;
        logic             is_br;
    } entry_t;

    entry_t [DEPTH-1:0] rob_q, rob_d;
    tag_t               head_q, head_d;
    tag_t               tail_q, tail_d;
    tag_t               br_tag_q, br_tag_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               br_pending_q, br_pending_d;

    entry_t             head_entry_c;
    logic               full_c;
    logic               empty_c;
    logic               mispredict_c;
    logic               alloc_fire_c;
    logic               commit_fire_c;

    // Age of a tag relative to the current head (0 = oldest).
    function automatic tag_t age(input tag_t tag, input tag_t head);
        return tag - head;
    endfunction

    assign head_entry_c  = rob_q[head_q];
    assign full_c        = (count_q == CNT_W'(DEPTH));
    assign empty_c       = (count_q == '0);
    assign mispredict_c  = rob_if.br_result_valid_i && !rob_if.br_result_hit_i && br_pending_q;
    assign alloc_fire_c  = rob_if.alloc_valid_i && rob_if.alloc_ready_o;
    // Head blocks while it is the unresolved branch itself.
    assign commit_fire_c = head_entry_c.valid && head_entry_c.done &&
                           !(br_pending_q && (head_q == br_tag_q));

    assign rob_if.alloc_ready_o       = !full_c && !(rob_if.br_result_valid_i && !rob_if.br_result_hit_i);
    assign rob_if.alloc_tag_o         = tail_q;
    assign rob_if.commit_valid_o      = commit_fire_c;
    assign rob_if.commit_pdst_o       = commit_fire_c ? head_entry_c.pdst : '0;
    assign rob_if.commit_prev_o       = commit_fire_c ? head_entry_c.prev : '0;
    assign rob_if.commit_prev_valid_o = commit_fire_c && head_entry_c.prev_v;
    assign rob_if.commit_spec_o       = commit_fire_c && br_pending_q &&
                                        (age(head_q, head_q) > age(br_tag_q, head_q));
    assign rob_if.branch_pending_o    = br_pending_q;
    assign rob_if.rob_empty_o         = empty_c;
    assign rob_if.rob_full_o          = full_c;

    // Next-state: writeback, commit, resolve/flush, then allocate.
    always_comb begin
        rob_d        = rob_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        br_pending_d = br_pending_q;
        br_tag_d     = br_tag_q;

        for (int unsigned k = 0; k < NUM_WB; k++) begin
            if (rob_if.wb_valid_i[WB_IW'(k)] && rob_q[rob_if.wb_tag_i[WB_IW'(k)]].valid) begin
                rob_d[rob_if.wb_tag_i[WB_IW'(k)]].done = 1'b1;
            end
        end

        if (commit_fire_c) begin
            rob_d[head_q].valid = 1'b0;
            head_d              = head_q + TAG_W'(1);
        end

        if (rob_if.br_result_valid_i && br_pending_q) begin
            br_pending_d = 1'b0;
        end

        if (mispredict_c) begin
            // Everything strictly younger than the branch is squashed.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (age(TAG_W'(i), head_q) > age(br_tag_q, head_q)) begin
                    rob_d[TAG_W'(i)].valid = 1'b0;
                end
            end
            tail_d  = br_tag_q + TAG_W'(1);
            count_d = CNT_W'(age(br_tag_q, head_q)) + CNT_W'(1) - CNT_W'(commit_fire_c);
        end else begin
            count_d = count_q + CNT_W'(alloc_fire_c) - CNT_W'(commit_fire_c);
        end

        if (alloc_fire_c) begin
            rob_d[tail_q] = '{valid:  1'b1,
                              done:   1'b0,
                              pdst:   rob_if.alloc_pdst_i,
                              pdst_v: rob_if.alloc_pdst_valid_i,
                              prev:   rob_if.alloc_prev_i,
                              prev_v: rob_if.alloc_prev_valid_i,
                              is_br:  rob_if.alloc_is_branch_i};
            tail_d = tail_q + TAG_W'(1);
            if (rob_if.alloc_is_branch_i) begin
                br_pending_d = 1'b1;
                br_tag_d     = tail_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rob_q        <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            br_pending_q <= 1'b0;
            br_tag_q     <= '0;
        end else begin
            rob_q        <= rob_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            br_pending_q <= br_pending_d;
            br_tag_q     <= br_tag_d;
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commits_q, perf_flushes_q, perf_full_cycles_q;

    // Free-running event counters, wrap at 2^32.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_commits_q     <= '0;
            perf_flushes_q     <= '0;
            perf_full_cycles_q <= '0;
        end else begin
            perf_commits_q     <= perf_commits_q + 32'(commit_fire_c);
            perf_flushes_q     <= perf_flushes_q + 32'(mispredict_c);
            perf_full_cycles_q <= perf_full_cycles_q + 32'(full_c);
        end
    end

    assign rob_if.perf_commits_o     = perf_commits_q;
    assign rob_if.perf_flushes_o     = perf_flushes_q;
    assign rob_if.perf_full_cycles_o = perf_full_cycles_q;
`endif

    // Only one branch checkpoint exists; rename must stall a second branch.
    a_single_branch: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(alloc_fire_c && rob_if.alloc_is_branch_i && br_pending_q));

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: queue-based reference model checked every cycle,
// plus hand-computed literal expectations posted by the stimulus thread.
module tb_rob_commit_unit;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TAG_W = 4;

    localparam int S_READY = 0, S_TAG = 1, S_CV = 2, S_PDST = 3, S_PREV = 4, S_EMPTY = 5,
                   S_FULL = 6, S_BRP = 7, S_MCOUNT = 8, S_NCOMMIT = 9;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    rob_commit_unit_if #(.DEPTH(DEPTH)) rif ();
    rob_commit_unit #(.DEPTH(DEPTH)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .rob_if(rif));

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         tag;
        logic [5:0] pdst;
        logic [5:0] prev;
        logic       prv;
        bit         done;
    } ment_t;

    ment_t mq[$];
    int    m_head  = 0;
    bit    m_brp   = 0;
    int    m_brtag = 0;
    int    checks  = 0;
    int    failures = 0;
    int    ncommit = 0;

    string lit_name[8];
    int    lit_sel[8];
    int    lit_exp[8];
    int    lit_n = 0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic int dut_val(input int sel);
        case (sel)
            S_READY:   return int'(rif.alloc_ready_o);
            S_TAG:     return int'(rif.alloc_tag_o);
            S_CV:      return int'(rif.commit_valid_o);
            S_PDST:    return int'(rif.commit_pdst_o);
            S_PREV:    return int'(rif.commit_prev_o);
            S_EMPTY:   return int'(rif.rob_empty_o);
            S_FULL:    return int'(rif.rob_full_o);
            S_BRP:     return int'(rif.branch_pending_o);
            S_MCOUNT:  return mq.size();
            S_NCOMMIT: return ncommit;
            default:   return -1;
        endcase
    endfunction

    // Reference model: compare this cycle's outputs, then advance to the next edge.
    always @(negedge clk_i) begin
        bit         e_full, e_empty, e_ready, e_cv;
        int         e_tag;
        logic [5:0] e_pdst, e_prev;
        logic       e_prv;
        if (!rst_ni) begin
            mq.delete();
            m_head  = 0;
            m_brp   = 0;
            m_brtag = 0;
        end
        e_full  = (mq.size() == DEPTH);
        e_empty = (mq.size() == 0);
        e_ready = !e_full && !(rif.br_result_valid_i && !rif.br_result_hit_i);
        e_tag   = (m_head + mq.size()) % DEPTH;
        e_cv    = (mq.size() > 0) && mq[0].done && !(m_brp && (mq[0].tag == m_brtag));
        e_pdst  = '0;
        e_prev  = '0;
        e_prv   = 1'b0;
        if (e_cv) begin
            e_pdst = mq[0].pdst;
            e_prev = mq[0].prev;
            e_prv  = mq[0].prv;
        end
        check("alloc_ready", int'(rif.alloc_ready_o), int'(e_ready));
        check("alloc_tag", int'(rif.alloc_tag_o), e_tag);
        check("commit_valid", int'(rif.commit_valid_o), int'(e_cv));
        check("commit_pdst", int'(rif.commit_pdst_o), int'(e_pdst));
        check("commit_prev", int'(rif.commit_prev_o), int'(e_prev));
        check("commit_prev_valid", int'(rif.commit_prev_valid_o), int'(e_prv));
        check("commit_spec", int'(rif.commit_spec_o), 0);
        check("branch_pending", int'(rif.branch_pending_o), int'(m_brp));
        check("rob_empty", int'(rif.rob_empty_o), int'(e_empty));
        check("rob_full", int'(rif.rob_full_o), int'(e_full));
        for (int j = 0; j < lit_n; j++) begin
            check(lit_name[j], dut_val(lit_sel[j]), lit_exp[j]);
        end
        if (rst_ni) begin
            for (int k = 0; k < 3; k++) begin
                if (rif.wb_valid_i[k]) begin
                    foreach (mq[j]) begin
                        if (mq[j].tag == int'(rif.wb_tag_i[k])) mq[j].done = 1;
                    end
                end
            end
            if (e_cv) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % DEPTH;
                ncommit++;
            end
            if (rif.br_result_valid_i && m_brp) begin
                if (!rif.br_result_hit_i) begin
                    while (mq.size() > 0 && mq[mq.size()-1].tag != m_brtag) void'(mq.pop_back());
                end
                m_brp = 0;
            end
            if (rif.alloc_valid_i && e_ready) begin
                mq.push_back('{tag: e_tag, pdst: rif.alloc_pdst_i, prev: rif.alloc_prev_i,
                               prv: rif.alloc_prev_valid_i, done: 1'b0});
                if (rif.alloc_is_branch_i) begin
                    m_brp   = 1;
                    m_brtag = e_tag;
                end
            end
        end
    end

    task automatic idle_inputs();
        rif.alloc_valid_i      = 1'b0;
        rif.alloc_pdst_i       = '0;
        rif.alloc_pdst_valid_i = 1'b0;
        rif.alloc_prev_i       = '0;
        rif.alloc_prev_valid_i = 1'b0;
        rif.alloc_is_branch_i  = 1'b0;
        rif.wb_valid_i         = '0;
        rif.wb_tag_i           = '0;
        rif.br_result_valid_i  = 1'b0;
        rif.br_result_hit_i    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        idle_inputs();
        lit_n = 0;
    endtask

    task automatic lit(input string n, input int sel, input int exp);
        lit_name[lit_n] = n;
        lit_sel[lit_n]  = sel;
        lit_exp[lit_n]  = exp;
        lit_n++;
    endtask

    task automatic alloc(input logic [5:0] pdst, input logic [5:0] prev, input logic prv,
                         input logic br);
        rif.alloc_valid_i      = 1'b1;
        rif.alloc_pdst_i       = pdst;
        rif.alloc_pdst_valid_i = (pdst != 6'd0);
        rif.alloc_prev_i       = prev;
        rif.alloc_prev_valid_i = prv;
        rif.alloc_is_branch_i  = br;
    endtask

    task automatic wb(input int port, input int tag);
        rif.wb_valid_i[port] = 1'b1;
        rif.wb_tag_i[port]   = TAG_W'(tag);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    // Branch at tag 3 with tags 0..2 before it and 4..7 after it.
    task automatic fill_with_branch();
        for (int t = 0; t < 8; t++) begin
            alloc(6'(20 + t), 6'(10 + t), 1'b1, t == 3);
            tick();
        end
    endtask

    initial begin
        int base;
        idle_inputs();
        tick();

        // Reset values
        lit("rst_ready", S_READY, 1);
        lit("rst_empty", S_EMPTY, 1);
        lit("rst_tag", S_TAG, 0);
        lit("rst_cv", S_CV, 0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // Out-of-order writeback, in-order commit
        alloc(6'd20, 6'd10, 1'b1, 1'b0); lit("oo_tag0", S_TAG, 0); tick();
        alloc(6'd21, 6'd11, 1'b1, 1'b0); tick();
        alloc(6'd22, 6'd12, 1'b1, 1'b0); tick();
        wb(0, 2); tick();
        wb(0, 1); tick();
        wb(0, 0); tick();
        lit("oo_cv0", S_CV, 1); lit("oo_prev0", S_PREV, 10); tick();
        lit("oo_cv1", S_CV, 1); lit("oo_prev1", S_PREV, 11); tick();
        lit("oo_cv2", S_CV, 1); lit("oo_prev2", S_PREV, 12); tick();
        lit("oo_empty", S_EMPTY, 1); tick();

        // Steady-state stream across the tail wrap
        base = ncommit;
        for (int i = 0; i < 40; i++) begin
            alloc(6'(i + 1), 6'(63 - i), i[0], 1'b0);
            if (i > 0) begin
                wb(0, (3 + i - 1) % 16);
                if (i % 3 == 0) wb(1, (3 + i - 1) % 16);
            end
            if (i == 12) lit("wrap_tag15", S_TAG, 15);
            if (i == 13) lit("wrap_tag0", S_TAG, 0);
            tick();
        end
        wb(0, (3 + 39) % 16); tick();
        tick();
        lit("wrap_commits", S_NCOMMIT, base + 40);
        lit("wrap_empty", S_EMPTY, 1);
        tick();

        // Mispredict: tags 4..7 squashed, tail back to 4
        do_reset();
        fill_with_branch();
        wb(0, 3); wb(1, 4); wb(2, 5); tick();
        wb(0, 6); wb(1, 7); lit("mp_brp_open", S_BRP, 1); tick();
        rif.br_result_valid_i = 1'b1;
        rif.br_result_hit_i   = 1'b0;
        alloc(6'd50, 6'd51, 1'b1, 1'b0);
        lit("mp_alloc_blocked", S_READY, 0);
        tick();
        lit("mp_count", S_MCOUNT, 4);
        lit("mp_tail", S_TAG, 4);
        lit("mp_brp_closed", S_BRP, 0);
        tick();
        alloc(6'd50, 6'd51, 1'b1, 1'b0); wb(0, 0); wb(1, 1); wb(2, 2);
        lit("mp_new_tag", S_TAG, 4);
        tick();
        wb(0, 4); tick();
        tick(); tick(); tick();
        lit("mp_new_cv", S_CV, 1); lit("mp_new_pdst", S_PDST, 50); tick();
        lit("mp_empty", S_EMPTY, 1); tick();

        // Hit: commit stalls at the branch until resolved, then 3..7 retire
        do_reset();
        fill_with_branch();
        wb(0, 0); wb(1, 1); wb(2, 2); tick();
        wb(0, 3); wb(1, 4); wb(2, 5); tick();
        wb(0, 6); wb(1, 7); tick();
        tick();
        lit("hit_stall", S_CV, 0); lit("hit_brp", S_BRP, 1); tick();
        rif.br_result_valid_i = 1'b1;
        rif.br_result_hit_i   = 1'b1;
        lit("hit_brp_resolve", S_BRP, 1);
        tick();
        lit("hit_brp_clear", S_BRP, 0); lit("hit_cv3", S_CV, 1); lit("hit_pdst3", S_PDST, 23); tick();
        for (int t = 4; t < 8; t++) begin
            lit("hit_pdst", S_PDST, 20 + t);
            tick();
        end
        lit("hit_empty", S_EMPTY, 1); tick();

        // Full, commit while full without bypass, then async reset mid-cycle
        for (int i = 0; i < 16; i++) begin
            alloc(6'(30 + i), 6'(i), 1'b1, 1'b0);
            if (i == 0) lit("full_tag_first", S_TAG, 8);
            if (i == 15) lit("full_tag_last", S_TAG, 7);
            tick();
        end
        alloc(6'd62, 6'd62, 1'b1, 1'b0); wb(0, 8);
        lit("full_full", S_FULL, 1); lit("full_ready", S_READY, 0); lit("full_cv", S_CV, 0);
        tick();
        alloc(6'd62, 6'd62, 1'b1, 1'b0);
        lit("fc_cv", S_CV, 1); lit("fc_full", S_FULL, 1); lit("fc_ready", S_READY, 0);
        lit("fc_pdst", S_PDST, 30);
        tick();
        alloc(6'd61, 6'd61, 1'b1, 1'b0); wb(0, 9);
        #3;
        rst_ni = 1'b0;
        lit("ar_empty", S_EMPTY, 1); lit("ar_full", S_FULL, 0); lit("ar_ready", S_READY, 1);
        lit("ar_tag", S_TAG, 0); lit("ar_cv", S_CV, 0); lit("ar_brp", S_BRP, 0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        alloc(6'd5, 6'd5, 1'b1, 1'b0); lit("post_rst_tag", S_TAG, 0); tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
